// File: rtl/regfile_arbiter_if.sv
// Bundles the requester handshakes, the clear control and the register-file port for regfile_arbiter.
// The arbiter uses the slave modport; the requesters and the register file together form the master side.
interface regfile_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          clr_start;
    logic          clr_busy;

    logic          a_valid;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_ready;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;

    logic          b_valid;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_ready;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;

    logic          rf_we;
    logic [AW-1:0] rf_wadd;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rf_radd;
    logic [DW-1:0] rf_rdata;

    modport slave (
        input  clr_start,
        output clr_busy,
        input  a_valid, a_we, a_addr, a_wdata,
        output a_ready, a_rvalid, a_rdata,
        input  b_valid, b_we, b_addr, b_wdata,
        output b_ready, b_rvalid, b_rdata,
        output rf_we, rf_wadd, rf_wdata, rf_radd,
        input  rf_rdata
    );

    modport master (
        output clr_start,
        input  clr_busy,
        output a_valid, a_we, a_addr, a_wdata,
        input  a_ready, a_rvalid, a_rdata,
        output b_valid, b_we, b_addr, b_wdata,
        input  b_ready, b_rvalid, b_rdata,
        input  rf_we, rf_wadd, rf_wdata, rf_radd,
        output rf_rdata
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one 16x8 register file between requesters A and B, with a zeroing sweep.
// Optional macro RF_DUAL_ISSUE_EN: grants a write and a read from different requesters in the same cycle.
module regfile_arbiter #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    regfile_arbiter_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        SERVE,
        CLEAR
    } state_e;

    state_e        state_q;
    logic [AW-1:0] clrCnt_q;
    logic          prioB_q;
    logic          clrBusy_q;
    logic          aRvalid_q;
    logic          bRvalid_q;
    logic [DW-1:0] aRdata_q;
    logic [DW-1:0] bRdata_q;

    logic          serve;
    logic          dualIssue;
    logic          contested;
    logic          grantA;
    logic          grantB;
    logic          aRvalid_d;
    logic          bRvalid_d;

    // clr_start pre-empts every request in the cycle it is seen
    assign serve = rst && (state_q == SERVE) && !bus.clr_start;

`ifdef RF_DUAL_ISSUE_EN
    assign dualIssue = serve && bus.a_valid && bus.b_valid && (bus.a_we != bus.b_we);
`else
    assign dualIssue = 1'b0;
`endif

    assign grantA    = serve && bus.a_valid && (dualIssue || !bus.b_valid || !prioB_q);
    assign grantB    = serve && bus.b_valid && (dualIssue || !bus.a_valid ||  prioB_q);
    assign contested = serve && bus.a_valid && bus.b_valid && !dualIssue;
    assign aRvalid_d = grantA && !bus.a_we;
    assign bRvalid_d = grantB && !bus.b_we;

    assign bus.a_ready  = grantA;
    assign bus.b_ready  = grantB;
    assign bus.a_rvalid = aRvalid_q;
    assign bus.a_rdata  = aRdata_q;
    assign bus.b_rvalid = bRvalid_q;
    assign bus.b_rdata  = bRdata_q;
    assign bus.clr_busy = clrBusy_q;

    // At most one granted requester writes and at most one reads, so the ports never collide
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_wadd  = '0;
        bus.rf_wdata = '0;
        bus.rf_radd  = '0;
        if (rst && state_q == CLEAR) begin
            bus.rf_we   = 1'b1;
            bus.rf_wadd = clrCnt_q;
        end else begin
            if (grantA) begin
                if (bus.a_we) begin
                    bus.rf_we    = 1'b1;
                    bus.rf_wadd  = bus.a_addr;
                    bus.rf_wdata = bus.a_wdata;
                end else begin
                    bus.rf_radd  = bus.a_addr;
                end
            end
            if (grantB) begin
                if (bus.b_we) begin
                    bus.rf_we    = 1'b1;
                    bus.rf_wadd  = bus.b_addr;
                    bus.rf_wdata = bus.b_wdata;
                end else begin
                    bus.rf_radd  = bus.b_addr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= SERVE;
            clrCnt_q  <= '0;
            prioB_q   <= 1'b0;
            clrBusy_q <= 1'b0;
            aRvalid_q <= 1'b0;
            bRvalid_q <= 1'b0;
            aRdata_q  <= '0;
            bRdata_q  <= '0;
        end else begin
            aRvalid_q <= aRvalid_d;
            bRvalid_q <= bRvalid_d;
            if (aRvalid_d) aRdata_q <= bus.rf_rdata;
            if (bRvalid_d) bRdata_q <= bus.rf_rdata;

            case (state_q)
                SERVE: begin
                    if (bus.clr_start) begin
                        state_q   <= CLEAR;
                        clrBusy_q <= 1'b1;
                        clrCnt_q  <= '0;
                    end else if (contested) begin
                        prioB_q   <= !prioB_q;
                    end
                end
                CLEAR: begin
                    if (clrCnt_q == AW'(DEPTH - 1)) begin
                        state_q   <= SERVE;
                        clrBusy_q <= 1'b0;
                        clrCnt_q  <= '0;
                    end else begin
                        clrCnt_q  <= clrCnt_q + AW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares one 16x8 register file (one write port, one asynchronous read port) between two requesters, A and B.
- Uses round-robin arbitration with a valid/ready handshake and a registered read response.
- Includes a clear sequencer that writes zero to every entry on command.
- Sits between the requesters and the register file, and drives all of the register file's address, data and write-enable inputs.

Parameters:
- DW, 8, data width
- AW, 4, address width; DEPTH = 2**AW = 16 entries

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low (asserted when 0)
clr_start  in  1  one-cycle pulse; starts the clear sweep
clr_busy  out  1  high while the sweep runs
a_valid  in  1  requester A has a request
a_we  in  1  A request type: 1 = write, 0 = read
a_addr  in  AW  A address
a_wdata  in  DW  A write data
a_ready  out  1  A request accepted this cycle (combinational)
a_rvalid  out  1  A read data valid (registered)
a_rdata  out  DW  A read data (registered)
b_valid, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata  same as A, for requester B
rf_we  out  1  register file write enable (combinational)
rf_wadd  out  AW  register file write address
rf_wdata  out  DW  register file write data
rf_radd  out  AW  register file read address
rf_rdata  in  DW  register file read data (asynchronous)

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=SERVE, clear counter=0, priority pointer=A.
  - a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, clr_busy=0.
  - Combinational outputs are 0 while rst=0.
- Reset mid-sweep aborts the sweep. Entries already cleared stay cleared; the rest are untouched.
- FSM states are SERVE and CLEAR.
- SERVE:
  - Exactly one request is granted per cycle.
  - If only one valid is high, that requester is granted.
  - If both are high, the requester named by the priority pointer is granted. The pointer then moves to the other requester.
  - The pointer changes only on a contested grant.
  - Grant to X: x_ready=1 in the same cycle; the transfer completes on that clk edge.
  - Write grant: rf_we=1, rf_wadd=x_addr, rf_wdata=x_wdata. The data lands at the edge.
  - Read grant: rf_radd=x_addr, rf_we=0. rf_rdata is captured into x_rdata at the edge. x_rvalid=1 for exactly the next cycle.
  - Read latency is 1 cycle. A read issued the cycle after a write to the same address returns the new data.
  - x_rdata holds its value until the next read grant to X.
  - No grant: rf_we=0, rf_radd=0, rf_wadd=0, rf_wdata=0.
- SERVE to CLEAR:
  - Transition occurs when clr_start=1 at an edge.
  - clr_start wins over any request in that cycle: both readys=0, no grant.
- CLEAR:
  - clr_busy=1, a_ready=b_ready=0.
  - rf_we=1, rf_wadd=counter, rf_wdata=0. The counter increments each cycle.
  - After the write to address DEPTH-1, the next state is SERVE and the counter returns to 0.
  - The sweep takes exactly 16 cycles.
  - clr_start during CLEAR is ignored.
  - An rvalid pending from the last SERVE cycle is still delivered in the first CLEAR cycle.
- Requesters must hold valid and request fields stable until ready. The block does not check this.

Optional Feature:
RF_DUAL_ISSUE_EN
- Defined, in SERVE:
  - If one requester's valid request is a write and the other's is a read, both are granted in the same cycle.
  - The write drives rf_we/rf_wadd/rf_wdata; the read drives rf_radd.
  - The read returns pre-write data, even on an address match.
  - The priority pointer is unchanged by a dual grant.
  - Two writes or two reads still use round-robin.
- Not defined: strictly one grant per cycle, as above.

Test Plan:
- Reset with rst=0 for 2 cycles -> all outputs 0, clr_busy=0; then A write addr 3 data 0x5A -> a_ready=1, rf_we=1, rf_wadd=3, rf_wdata=0x5A.
- A read addr 3 the cycle after the write -> a_rvalid=1 next cycle, a_rdata=0x5A; b_rvalid stays 0.
- A and B both write, held for 4 cycles (A addr 1/0x11, B addr 2/0x22) -> grants alternate A, B, A, B; each ready drops once its own request completes.
- Fill all 16 entries with nonzero data, pulse clr_start while A is valid -> a_ready=0, clr_busy=1 for exactly 16 cycles, rf_wadd steps 0..15 with rf_wdata=0; reading every address afterwards returns 0x00.
- rst=0 after clear cycle 5 -> state SERVE, clr_busy=0 next cycle; addresses 0..4 read 0, addresses 5..15 keep their old data.
- With RF_DUAL_ISSUE_EN: addr 7 holds 0x33; A writes 0x44 to addr 7 while B reads addr 7 in the same cycle -> both readys=1, b_rdata=0x33; the next B read returns 0x44.
